// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divide sequencer (DIV/DIVU/REM/REMU) with an internal restoring datapath.
// Define DIV_REM_REUSE_EN to keep the last normal-path operands and results so that a follow-up divide can complete in one cycle.
module div_sequencer #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  div_op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        kill,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int N = 32 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t      state;
  logic [5:0]  count;
  logic [63:0] rq;
  logic [31:0] divisor;
  logic        q_neg;
  logic        r_neg;
  logic        op_rem;

  logic        is_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        special_zero;
  logic        special_ovf;
  logic [63:0] step_rq;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic        accept;
  logic        reuse_hit;
  logic [31:0] reuse_result;

  // One or more restoring steps on the remainder:quotient pair; the shifted
  // remainder needs 33 bits because it can exceed 2^32-1 before the subtract.
  function automatic logic [63:0] div_steps(input logic [63:0] acc, input logic [31:0] d);
    logic [31:0] rem;
    logic [31:0] quo;
    logic [32:0] sh;
    logic [32:0] diff;
    rem = acc[63:32];
    quo = acc[31:0];
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      sh   = {rem, quo[31]};
      quo  = {quo[30:0], 1'b0};
      diff = sh - {1'b0, d};
      if (!diff[32]) begin
        rem    = diff[31:0];
        quo[0] = 1'b1;
      end else begin
        rem = sh[31:0];
      end
    end
    return {rem, quo};
  endfunction

  assign is_signed    = ~div_op[0];
  assign abs_a        = (is_signed && rs1[31]) ? -rs1 : rs1;
  assign abs_b        = (is_signed && rs2[31]) ? -rs2 : rs2;
  assign special_zero = (rs2 == 32'h0);
  assign special_ovf  = is_signed && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  assign step_rq      = div_steps(rq, divisor);
  assign q_fin        = q_neg ? -rq[31:0] : rq[31:0];
  assign r_fin        = r_neg ? -rq[63:32] : rq[63:32];
  assign accept       = (state == IDLE) && start && !kill;

  assign stall = accept || (state == RUN) || (state == FIX);

`ifdef DIV_REM_REUSE_EN
  logic [31:0] last_a;
  logic [31:0] last_b;
  logic        last_unsigned;
  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_valid;

  assign reuse_hit    = last_valid && (rs1 == last_a) && (rs2 == last_b) && (div_op[0] == last_unsigned);
  assign reuse_result = div_op[1] ? last_r : last_q;

  // Operands are captured at every fresh accept; results only become valid
  // once a normal-path divide reaches FIX without being killed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_a        <= 32'h0;
      last_b        <= 32'h0;
      last_unsigned <= 1'b0;
      last_q        <= 32'h0;
      last_r        <= 32'h0;
      last_valid    <= 1'b0;
    end else if (kill) begin
      last_valid <= 1'b0;
    end else if (accept && !reuse_hit) begin
      last_a        <= rs1;
      last_b        <= rs2;
      last_unsigned <= div_op[0];
      last_valid    <= 1'b0;
    end else if (state == FIX) begin
      last_q     <= q_fin;
      last_r     <= r_fin;
      last_valid <= 1'b1;
    end
  end
`else
  assign reuse_hit    = 1'b0;
  assign reuse_result = 32'h0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= 6'd0;
      rq      <= 64'h0;
      divisor <= 32'h0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      op_rem  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 32'h0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_rem <= div_op[1];
              if (reuse_hit) begin
                result <= reuse_result;
                done   <= 1'b1;
                state  <= DONE;
              end else if (special_zero) begin
                result <= div_op[1] ? rs1 : 32'hFFFF_FFFF;
                done   <= 1'b1;
                state  <= DONE;
              end else if (special_ovf) begin
                result <= div_op[1] ? 32'h0 : 32'h8000_0000;
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                rq      <= {32'h0, abs_a};
                divisor <= abs_b;
                q_neg   <= is_signed && (rs1[31] ^ rs2[31]);
                r_neg   <= is_signed && rs1[31];
                count   <= 6'd0;
                busy    <= 1'b1;
                state   <= RUN;
              end
            end
          end
          RUN: begin
            rq    <= step_rq;
            count <= count + 6'd1;
            if (count == 6'(N - 1)) state <= FIX;
          end
          FIX: begin
            result <= op_rem ? r_fin : q_fin;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed divides push expected results; a monitor checks them on done.
// Reuse-dependent latencies follow DIV_REM_REUSE_EN.
module tb_div_sequencer;

  localparam int LAT1 = 32 + 2;
  localparam int LAT4 = 8 + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  div_op = 2'b00;
  logic [31:0] rs1 = 32'h0;
  logic [31:0] rs2 = 32'h0;
  logic        kill = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  logic        start4 = 1'b0;
  logic [1:0]  div_op4 = 2'b00;
  logic [31:0] rs1_4 = 32'h0;
  logic [31:0] rs2_4 = 32'h0;
  logic        kill4 = 1'b0;
  logic        stall4, busy4, done4;
  logic [31:0] result4;

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] due;
  } exp_t;
  exp_t sb[$];

`ifdef DIV_REM_REUSE_EN
  bit          mv = 1'b0;
  logic [31:0] ma, mb;
  logic        mu;
`endif

  div_sequencer #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .div_op(div_op),
    .rs1(rs1), .rs2(rs2), .kill(kill),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  div_sequencer #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .div_op(div_op4),
    .rs1(rs1_4), .rs2(rs2_4), .kill(kill4),
    .stall(stall4), .busy(busy4), .done(done4), .result(result4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got done=1 result %h expected no done", result);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_result", result, e.res);
        checkOutput("sb_done_cycle", cyc, e.due);
      end
    end
  end

  task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res);
    exp_t e;
    int   lat;
    bit   special;
    bit   hit;
    special = (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    hit = 1'b0;
`ifdef DIV_REM_REUSE_EN
    hit = mv && (a == ma) && (b == mb) && (op[0] == mu);
    if (!hit) begin
      mv = 1'b0;
      ma = a;
      mb = b;
      mu = op[0];
    end
`endif
    lat = (special || hit) ? 1 : LAT1;
    @(negedge clk);
    start = 1'b1;
    div_op = op;
    rs1 = a;
    rs2 = b;
    e.res = exp_res;
    e.due = 32'(cyc + lat);
    sb.push_back(e);
    #1 checkOutput({name, "_stall_c0"}, 32'(stall), 32'd1);
    for (int r = 1; r <= lat; r++) begin
      @(negedge clk);
      #1;
      checkOutput({name, "_stall"}, 32'(stall), 32'(r < lat));
      checkOutput({name, "_busy"}, 32'(busy), 32'(r < lat));
    end
    start = 1'b0;
`ifdef DIV_REM_REUSE_EN
    if (!special && !hit) mv = 1'b1;
`endif
  endtask

  task automatic run4(input string name, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res, input int lat);
    bit got;
    got = 1'b0;
    @(negedge clk);
    start4 = 1'b1;
    div_op4 = op;
    rs1_4 = a;
    rs2_4 = b;
    for (int r = 1; r <= lat + 8; r++) begin
      @(negedge clk);
      if (done4) begin
        got = 1'b1;
        checkOutput({name, "_result"}, result4, exp_res);
        checkOutput({name, "_done_cycle"}, 32'(r), 32'(lat));
        break;
      end
    end
    start4 = 1'b0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: got no done expected done at cycle %0d", name, lat);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'h0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus("div_m20_3",  2'b00, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFA);
    applyStimulus("rem_m20_3",  2'b10, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE);
    applyStimulus("remu_max_16", 2'b11, 32'hFFFF_FFFF, 32'h10,      32'h0000_000F);
    applyStimulus("divu_max_16", 2'b01, 32'hFFFF_FFFF, 32'h10,      32'h0FFF_FFFF);
    applyStimulus("div_by0",    2'b00, 32'h0000_1234, 32'h0,        32'hFFFF_FFFF);
    applyStimulus("rem_by0",    2'b10, 32'h0000_1234, 32'h0,        32'h0000_1234);
    applyStimulus("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    applyStimulus("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    applyStimulus("divu_big",   2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    applyStimulus("remu_big",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    applyStimulus("div_7_m2",   2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    applyStimulus("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF);

    // Kill during RUN: no done pulse may follow and the block must be idle next cycle.
    @(negedge clk);
    start = 1'b1;
    div_op = 2'b00;
    rs1 = 32'd100;
    rs2 = 32'd7;
    repeat (15) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("kill_stall", 32'(stall), 32'd0);
    checkOutput("kill_busy", 32'(busy), 32'd0);
`ifdef DIV_REM_REUSE_EN
    mv = 1'b0;
`endif
    repeat (40) @(negedge clk);
    applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 32'h0000_000E);

    // Reset in the middle of a divide returns everything to zero at once.
    @(negedge clk);
    start = 1'b1;
    div_op = 2'b00;
    rs1 = 32'hFFFF_FFEC;
    rs2 = 32'd3;
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_result", result, 32'h0);
    start = 1'b0;
`ifdef DIV_REM_REUSE_EN
    mv = 1'b0;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("rst_idle_stall", 32'(stall), 32'd0);
      checkOutput("rst_idle_busy", 32'(busy), 32'd0);
    end
    repeat (40) @(negedge clk);

    applyStimulus("div_100_7", 2'b00, 32'd100, 32'd7, 32'h0000_000E);
    applyStimulus("rem_100_7", 2'b10, 32'd100, 32'd7, 32'h0000_0002);

    run4("remu4_max_16", 2'b11, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, LAT4);
    run4("div4_m20_3",   2'b00, 32'hFFFF_FFEC, 32'd3,  32'hFFFF_FFFA, LAT4);
    run4("div4_by0",     2'b00, 32'h0000_1234, 32'h0,  32'hFFFF_FFFF, 1);

    repeat (5) @(negedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL sb_pending: got %0d outstanding expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
